// File: rtl/gate_op_scheduler.sv
// Round-robin scheduler sharing one registered NAND/OR/NOT/XOR unit among NREQ requesters.
// Optional completed-operation counter enabled by defining GATE_OP_SCHED_STATS_EN.
module gate_op_scheduler #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       op,
  input  logic [WIDTH*NREQ-1:0]   a,
  input  logic [WIDTH*NREQ-1:0]   b,
  output logic [NREQ-1:0]         gnt,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [1:0]              res_id,
  output logic [WIDTH-1:0]        res_data,
  output logic                    busy,
  output logic [15:0]             ops_done
);

  localparam int unsigned IDW   = 2;
  localparam int unsigned OPW   = 2;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [IDW-1:0]   id;
  } gate_cmd_t;

  state_e           state_q;
  logic [IDW-1:0]   rr_q;
  gate_cmd_t        cmd_q;
  logic             res_valid_q;
  logic [IDW-1:0]   res_id_q;
  logic [WIDTH-1:0] res_data_q;
  logic             busy_q;

  logic [IDW-1:0]   cand   [NREQ];
  logic             pick_found;
  logic [IDW-1:0]   pick_idx;
  logic [WIDTH-1:0] alu_res;
  logic [IDW-1:0]   rr_d;

  // Search order: rr, rr+1, ... wrapping modulo NREQ.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand[i] = IDW'((32'(rr_q) + i) % NREQ);
    end
  end

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!pick_found && req[cand[i]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[i];
      end
    end
  end

  // Grant is only offered while idle; it is the accept strobe for the chosen requester.
  always_comb begin
    gnt = '0;
    if (state_q == S_IDLE && pick_found) begin
      gnt[pick_idx] = 1'b1;
    end
  end

  always_comb begin
    unique case (cmd_q.op)
      2'b00:   alu_res = ~(cmd_q.a & cmd_q.b);
      2'b01:   alu_res = cmd_q.a | cmd_q.b;
      2'b10:   alu_res = ~cmd_q.a;
      default: alu_res = cmd_q.a ^ cmd_q.b;
    endcase
  end

  assign rr_d = IDW'((32'(cmd_q.id) + 32'd1) % NREQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      cmd_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pick_found) begin
            cmd_q.op <= op[OPW*pick_idx +: OPW];
            cmd_q.a  <= a[WIDTH*pick_idx +: WIDTH];
            cmd_q.b  <= b[WIDTH*pick_idx +: WIDTH];
            cmd_q.id <= pick_idx;
            busy_q   <= 1'b1;
            state_q  <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_data_q  <= alu_res;
          res_id_q    <= cmd_q.id;
          rr_q        <= rr_d;
          res_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          // Completion always passes through IDLE before the next grant.
          if (res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;
  assign busy      = busy_q;

`ifdef GATE_OP_SCHED_STATS_EN
  logic [CNT_W-1:0] ops_done_q;
  logic [CNT_W-1:0] ops_done_d;

  // Saturating count of completed result transfers.
  always_comb begin
    ops_done_d = ops_done_q;
    if (res_valid_q && res_ready && ops_done_q != {CNT_W{1'b1}}) begin
      ops_done_d = ops_done_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_done_q <= '0;
    end else begin
      ops_done_q <= ops_done_d;
    end
  end

  assign ops_done = ops_done_q;
`else
  assign ops_done = CNT_W'(0);
`endif

endmodule

// File: tb/tb_gate_op_scheduler.sv
// Directed self-checking bench for gate_op_scheduler; expected values are hand-computed.
module tb_gate_op_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  gnt;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_id;
  logic [7:0]  res_data;
  logic        busy;
  logic [15:0] ops_done;

  int total = 0;
  int bad   = 0;
  int exp_ops = 0;
  int rr_seq1 [6] = '{0, 1, 2, 3, 0, 1};
  int rr_seq2 [4] = '{3, 1, 3, 1};

  gate_op_scheduler #(.WIDTH(8), .NREQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op        (op),
    .a         (a),
    .b         (b),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_data  (res_data),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_ops_out();
`ifdef GATE_OP_SCHED_STATS_EN
    return 32'(exp_ops);
`else
    return 32'd0;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_ops = 0;
  endtask

  task automatic wait_grant(input int k, input string tag);
    int n = 0;
    @(negedge clk);
    while (gnt == 4'd0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(gnt), 32'(1 << k));
  endtask

  task automatic wait_resp(input string tag);
    int n = 0;
    @(negedge clk);
    while (!res_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(res_valid), 32'd1);
  endtask

  task automatic set_req(input int k, input logic [1:0] opc, input logic [7:0] av, input logic [7:0] bv);
    op[2*k +: 2] = opc;
    a[8*k +: 8]  = av;
    b[8*k +: 8]  = bv;
  endtask

  // One isolated operation with res_ready high: grant T, valid at T+2, idle at T+3.
  task automatic run_op(input int k, input logic [1:0] opc, input logic [7:0] av,
                        input logic [7:0] bv, input logic [7:0] exp_data, input string tag);
    @(posedge clk);
    #1;
    set_req(k, opc, av, bv);
    req       = 4'd0;
    req[k]    = 1'b1;
    res_ready = 1'b1;
    wait_grant(k, {tag, "_gnt"});
    @(posedge clk);
    #1 req = 4'd0;
    @(negedge clk);
    check({tag, "_exec_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_exec_busy"}, 32'(busy), 32'd1);
    check({tag, "_exec_valid"}, 32'(res_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_data"}, 32'(res_data), 32'(exp_data));
    check({tag, "_id"}, 32'(res_id), 32'(k));
    exp_ops++;
    @(negedge clk);
    check({tag, "_done_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_done_busy"}, 32'(busy), 32'd0);
    check({tag, "_ops"}, 32'(ops_done), exp_ops_out());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req = '0;
    op = '0;
    a = '0;
    b = '0;
    res_ready = 1'b0;

    do_reset();
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_id", 32'(res_id), 32'd0);
    check("rst_data", 32'(res_data), 32'd0);
    check("rst_ops", 32'(ops_done), 32'd0);
    for (int i = 0; i < 10; i++) begin
      check("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end

    run_op(0, 2'b00, 8'hF0, 8'h3C, 8'hCF, "single");

    run_op(1, 2'b01, 8'hA5, 8'h0F, 8'hAF, "or");
    run_op(2, 2'b10, 8'hA5, 8'h0F, 8'h5A, "not");
    run_op(3, 2'b11, 8'hA5, 8'h0F, 8'hAA, "xor");
    run_op(0, 2'b00, 8'hA5, 8'h0F, 8'hFA, "nand");

    // rr is 1 after the last grant to 0; round robin begins at 1 here, so realign to 0.
    run_op(3, 2'b11, 8'h00, 8'h00, 8'h00, "align");

    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) set_req(k, 2'b11, 8'(k * 16 + 1), 8'h0F);
    req = 4'b1111;
    res_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      wait_grant(rr_seq1[j], "rr_all");
      exp_ops++;
    end
    @(posedge clk);
    #1 req = 4'b1010;
    for (int j = 0; j < 4; j++) begin
      wait_grant(rr_seq2[j], "rr_alt");
      exp_ops++;
    end
    @(posedge clk);
    #1 req = 4'd0;
    wait_resp("rr_drain");
    check("rr_drain_id", 32'(res_id), 32'd1);
    @(negedge clk);
    check("rr_idle_busy", 32'(busy), 32'd0);
    check("rr_ops", 32'(ops_done), exp_ops_out());

    // Backpressure: rr=2, requester 2 wins over 0 and then holds in RESP.
    @(posedge clk);
    #1;
    set_req(2, 2'b11, 8'hFF, 8'h81);
    set_req(0, 2'b10, 8'h3C, 8'h00);
    req = 4'b0101;
    res_ready = 1'b0;
    wait_grant(2, "bp_gnt");
    @(posedge clk);
    #1 req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(res_valid), 32'd1);
      check("bp_data", 32'(res_data), 32'h7E);
      check("bp_id", 32'(res_id), 32'd2);
      check("bp_gnt0", 32'(gnt), 32'd0);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(negedge clk);
    check("bp_last_valid", 32'(res_valid), 32'd1);
    check("bp_last_gnt", 32'(gnt), 32'd0);
    exp_ops++;
    @(negedge clk);
    check("bp_next_gnt", 32'(gnt), 32'b0001);
    exp_ops++;
    @(posedge clk);
    #1 req = 4'd0;
    wait_resp("bp_drain");
    check("bp_drain_data", 32'(res_data), 32'hC3);
    check("bp_drain_id", 32'(res_id), 32'd0);
    @(negedge clk);
    check("bp_ops", 32'(ops_done), exp_ops_out());

    // Reset while a result is pending in RESP.
    do_reset();
    run_op(0, 2'b00, 8'hFF, 8'h0F, 8'hF0, "cnt0");
    run_op(1, 2'b01, 8'h10, 8'h01, 8'h11, "cnt1");
    run_op(2, 2'b11, 8'h55, 8'hFF, 8'hAA, "cnt2");
    check("cnt_three", 32'(ops_done), exp_ops_out());
    @(posedge clk);
    #1;
    set_req(1, 2'b01, 8'h0F, 8'hF0);
    req = 4'b0010;
    res_ready = 1'b0;
    wait_grant(1, "mid_gnt");
    @(posedge clk);
    #1 req = 4'd0;
    @(negedge clk);
    @(negedge clk);
    check("mid_valid", 32'(res_valid), 32'd1);
    #2 rst = 1'b1;
    exp_ops = 0;
    #1;
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_ops", 32'(ops_done), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data", 32'(res_data), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    set_req(1, 2'b10, 8'hF0, 8'h00);
    set_req(2, 2'b10, 8'h0F, 8'h00);
    req = 4'b0110;
    res_ready = 1'b1;
    wait_grant(1, "post_rst_rr");
    @(posedge clk);
    #1 req = 4'd0;
    wait_resp("post_rst_drain");
    check("post_rst_data", 32'(res_data), 32'h0F);
    exp_ops++;
    @(negedge clk);
    check("post_rst_ops", 32'(ops_done), exp_ops_out());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
